// File: rtl/gate_tt_sequencer_pkg.sv
// gate_tt_sequencer_pkg: state encoding and row-count helper shared by the truth-table sequencer
package gate_tt_sequencer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int num_rows(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/gate_tt_sequencer_if.sv
// gate_tt_sequencer_if: control, gate drive/sense and result signals of the truth-table sequencer
interface gate_tt_sequencer_if
  import gate_tt_sequencer_pkg::*;
#(
  parameter int N_IN = 2
);
  logic                      start;
  logic                      gate_out;
  logic [N_IN-1:0]           gate_in;
  logic                      busy;
  logic                      done;
  logic                      pass;
  logic [N_IN:0]             err_count;
  logic [num_rows(N_IN)-1:0] fail_mask;

  modport master (output start, gate_out, input gate_in, busy, done, pass, err_count, fail_mask);
  modport slave  (input start, gate_out, output gate_in, busy, done, pass, err_count, fail_mask);
endinterface

// File: rtl/gate_tt_sequencer_hold_timer.sv
// gate_tt_sequencer_hold_timer: per-row hold counter, wraps after HOLD_CYCLES and flags the last cycle
module gate_tt_sequencer_hold_timer #(
  parameter int HOLD_CYCLES = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);
  localparam int W = $clog2(HOLD_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  assign last_o = cnt_q == W'(HOLD_CYCLES - 1);
  assign cnt_d  = clr_i ? '0 : !en_i ? cnt_q : last_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
endmodule

// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer: sweeps every gate input row, checks the gate output against EXPECT, reports results
// GATE_TT_STOP_ON_FAIL_EN ends the sweep at the first mismatching row.
module gate_tt_sequencer
  import gate_tt_sequencer_pkg::*;
#(
  parameter int                        N_IN        = 2,
  parameter int                        HOLD_CYCLES = 50,
  parameter logic [num_rows(N_IN)-1:0] EXPECT      = 'b0111
) (
  input logic                clk,
  input logic                reset_n,
  gate_tt_sequencer_if.slave bus
);
  localparam int ROWS = num_rows(N_IN);

  if (HOLD_CYCLES < 2) begin : g_hold_chk
    $error("HOLD_CYCLES must be at least 2");
  end

  state_e          state_q, state_d;
  logic [N_IN-1:0] row_q, row_d;
  logic [N_IN:0]   err_q, err_d;
  logic [ROWS-1:0] mask_q, mask_d;
  logic            pass_q, pass_d;
  logic            last, mism, sweep_end;

  gate_tt_sequencer_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr_i  (state_q != ST_RUN),
    .en_i   (state_q == ST_RUN),
    .last_o (last)
  );

  assign mism = last && (bus.gate_out != EXPECT[row_q]);
`ifdef GATE_TT_STOP_ON_FAIL_EN
  assign sweep_end = row_q == N_IN'(ROWS - 1) || mism;
`else
  assign sweep_end = row_q == N_IN'(ROWS - 1);
`endif

  // pass is taken from err_d so a mismatch on the final row is counted
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    err_d   = err_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d = ST_RUN;
        row_d   = '0;
        err_d   = '0;
        mask_d  = '0;
        pass_d  = 1'b0;
      end
      ST_RUN: begin
        if (mism) begin
          err_d         = err_q + 1'b1;
          mask_d[row_q] = 1'b1;
        end
        if (last && sweep_end) begin
          state_d = ST_DONE;
          row_d   = '0;
          pass_d  = err_d == '0;
        end else if (last) row_d = row_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end

  assign bus.gate_in   = row_q;
  assign bus.busy      = state_q == ST_RUN;
  assign bus.done      = state_q == ST_DONE;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_mask = mask_q;
endmodule
